hsiao2_64_decoder: RTL and testbench

- Registered Hsiao (72,64) SEC-DED decoder: takes a 72-bit codeword, computes an 8-bit syndrome, corrects any single-bit error, and flags double and other uncorrectable errors.
- Sits on the read path after ECC-protected storage or a link.
- Pairs with the team's matching Hsiao (72,64) encoder, which uses the same H matrix.

---
 rtl/hsiao2_64_pkg.sv | 55 +++++
 rtl/hsiao2_64_decoder_syndrome.sv | 26 ++
 rtl/hsiao2_64_decoder.sv | 68 ++++++
 tb/tb_hsiao2_64_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hsiao2_64_pkg.sv
// Shared constants and H matrix for the Hsiao (72,64) SEC-DED encoder/decoder pair.
// Columns: 56 weight-3 vectors, 8 weight-5 vectors, then one-hot check columns.
package hsiao2_64_pkg;

  localparam int DATA_W = 64;
  localparam int CHK_W  = 8;
  localparam int CODE_W = DATA_W + CHK_W;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CORR  = 2'd1,
    ERR_FATAL = 2'd2
  } err_class_t;

  typedef logic [0:CODE_W-1][CHK_W-1:0] h_matrix_t;

  // Walking the 8-bit values in ascending order yields both column families already sorted.
  function automatic h_matrix_t build_h();
    h_matrix_t  h;
    int         n3;
    int         n5;
    int         w;
    logic [7:0] vec;
    h  = '0;
    n3 = 0;
    n5 = 0;
    for (int v = 1; v < 256; v++) begin
      vec = v[7:0];
      w   = $countones(vec);
      if (w == 3 && n3 < 56) begin
        h[n3] = vec;
        n3++;
      end else if (w == 5 && n5 < 8) begin
        h[56 + n5] = vec;
        n5++;
      end
    end
    for (int k = 0; k < CHK_W; k++) begin
      h[DATA_W + k] = 8'(1 << k);
    end
    return h;
  endfunction

  localparam h_matrix_t H_COL = build_h();

  function automatic logic [CHK_W-1:0] calc_syndrome(input logic [0:CODE_W-1] code);
    logic [CHK_W-1:0] s;
    s = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) s ^= H_COL[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/hsiao2_64_decoder_syndrome.sv
// Combinational syndrome, single-error position mask and error classification.
module hsiao2_64_syndrome
  import hsiao2_64_pkg::*;
(
  input  logic [0:CODE_W-1] i_code,
  output logic [CHK_W-1:0]  syndrome,
  output logic [0:CODE_W-1] err_mask,
  output err_class_t        err_class
);

  assign syndrome = calc_syndrome(i_code);

  // No column is zero, so a clean syndrome can never raise a mask bit.
  for (genvar gi = 0; gi < CODE_W; gi++) begin : g_match
    assign err_mask[gi] = (syndrome == H_COL[gi]);
  end

  always_comb begin
    err_class = ERR_NONE;
    if (syndrome != '0) begin
      if (|err_mask) err_class = ERR_CORR;
      else           err_class = ERR_FATAL;
    end
  end

endmodule

// File: rtl/hsiao2_64_decoder.sv
// Registered Hsiao (72,64) SEC-DED decoder, one cycle latency, full throughput.
// reset_n is an active-high synchronous reset despite its name.
module hsiao2_64_decoder
  import hsiao2_64_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [0:CODE_W-1] i_code,
  output logic [0:DATA_W-1] o_data,
  output logic              o_valid,
  output logic              o_err_corr,
  output logic              o_err_detec,
  output logic              o_err_fatal
);

  logic [CHK_W-1:0]  syndrome;
  logic [0:CODE_W-1] err_mask;
  err_class_t        err_class;
  logic [0:DATA_W-1] data_next;
  logic              corr_next;
  logic              detec_next;
  logic              fatal_next;

  logic [0:DATA_W-1] data_reg;
  logic              valid_reg;
  logic              corr_reg;
  logic              detec_reg;
  logic              fatal_reg;

  hsiao2_64_syndrome u_syndrome (
    .i_code    (i_code),
    .syndrome  (syndrome),
    .err_mask  (err_mask),
    .err_class (err_class)
  );

  // A check-bit hit leaves the data slice of the mask at zero, so data passes through.
  assign data_next  = i_code[0:DATA_W-1] ^ err_mask[0:DATA_W-1];
  assign corr_next  = |err_mask;
  assign detec_next = (syndrome != '0);
  assign fatal_next = (err_class == ERR_FATAL);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      corr_reg  <= 1'b0;
      detec_reg <= 1'b0;
      fatal_reg <= 1'b0;
    end else if (enable) begin
      data_reg  <= data_next;
      valid_reg <= 1'b1;
      corr_reg  <= corr_next;
      detec_reg <= detec_next;
      fatal_reg <= fatal_next;
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign o_data      = data_reg;
  assign o_valid     = valid_reg;
  assign o_err_corr  = corr_reg;
  assign o_err_detec = detec_reg;
  assign o_err_fatal = fatal_reg;

endmodule

// File: tb/tb_hsiao2_64_decoder.sv
// Scoreboard bench for hsiao2_64_decoder: directed vectors plus a single-bit flip sweep.
module tb_hsiao2_64_decoder;

  typedef struct packed {
    logic [0:63] data;
    logic        corr;
    logic        detec;
    logic        fatal;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [0:71] i_code;
  logic [0:63] o_data;
  logic        o_valid;
  logic        o_err_corr;
  logic        o_err_detec;
  logic        o_err_fatal;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t last_exp;
  logic [7:0] tb_h [0:71];

  hsiao2_64_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .i_code      (i_code),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_err_corr  (o_err_corr),
    .o_err_detec (o_err_detec),
    .o_err_fatal (o_err_fatal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [0:63] d, input logic c, input logic de, input logic f);
    exp_t e;
    e.data  = d;
    e.corr  = c;
    e.detec = de;
    e.fatal = f;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Columns built from bit positions (c > b > a) rather than by scanning values.
  task automatic build_tb_h();
    int n;
    logic [7:0] w5 [0:7];
    w5 = '{8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3E, 8'h4F, 8'h57};
    n = 0;
    for (int c = 2; c < 8; c++)
      for (int b = 1; b < c; b++)
        for (int a = 0; a < b; a++) begin
          tb_h[n] = 8'((1 << c) | (1 << b) | (1 << a));
          n++;
        end
    for (int k = 0; k < 8; k++) tb_h[56 + k] = w5[k];
    for (int k = 0; k < 8; k++) tb_h[64 + k] = 8'(1 << k);
  endtask

  function automatic logic [0:71] encode(input logic [0:63] d);
    logic [0:71] c;
    c = {d, 8'h00};
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 64; j++)
        if (tb_h[j][k]) c[64 + k] ^= d[j];
    return c;
  endfunction

  task automatic send(input logic [0:71] c, input exp_t e);
    @(negedge clk);
    i_code = c;
    enable = 1'b1;
    exp_q.push_back(e);
    last_exp = e;
    $display("send code=%h exp data=%h corr=%b detec=%b fatal=%b", c, e.data, e.corr, e.detec, e.fatal);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_valid"}, 64'(o_valid), 64'd0);
    cmp({tag, "_data"},  64'(o_data), 64'd0);
    cmp({tag, "_flags"}, 64'({o_err_corr, o_err_detec, o_err_fatal}), 64'd0);
  endtask

  // Monitor: pops one expectation per valid output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid with data %h, expected no output", o_data);
        end else begin
          e = exp_q.pop_front();
          $display("recv data=%h corr=%b detec=%b fatal=%b", o_data, o_err_corr, o_err_detec, o_err_fatal);
          cmp("data", 64'(o_data), 64'(e.data));
          cmp("err_corr", 64'(o_err_corr), 64'(e.corr));
          cmp("err_detec", 64'(o_err_detec), 64'(e.detec));
          cmp("err_fatal", 64'(o_err_fatal), 64'(e.fatal));
          cmp("corr_fatal_excl", 64'(o_err_corr & o_err_fatal), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:63] base_d;
    logic [0:71] base_c;
    logic [0:71] cw;

    build_tb_h();
    reset_n = 1'b1;
    enable  = 1'b0;
    i_code  = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    check_zero("reset");

    send(72'h0, mk(64'h0, 1'b0, 1'b0, 1'b0));
    send(72'h1000, mk(64'h0, 1'b1, 1'b1, 1'b0));      // index 59, data
    send(72'h80000, mk(64'h0, 1'b1, 1'b1, 1'b0));     // index 52, data
    send(72'h1, mk(64'h0, 1'b1, 1'b1, 1'b0));         // c7
    send(72'h50000, mk(64'h500, 1'b0, 1'b1, 1'b1));   // indices 53,55: double
    send(72'ha000, mk(64'ha0, 1'b0, 1'b1, 1'b1));     // indices 56,58: 0x1F^0x37=0x28
    send(72'hb0000, mk(64'hb00, 1'b0, 1'b1, 1'b1));   // 0xC4^0xD0^0xE0=0xF4: weight 5, no column

    base_d = {$urandom(), $urandom()};
    base_c = encode(base_d);
    send(base_c, mk(base_d, 1'b0, 1'b0, 1'b0));
    send(72'h80, mk(64'h0, 1'b1, 1'b1, 1'b0));        // c0
    send(72'h0, mk(64'h0, 1'b0, 1'b0, 1'b0));
    send(72'h80_0000_0000_0000_0000, mk(64'h0, 1'b1, 1'b1, 1'b0)); // index 0

    @(negedge clk);
    enable = 1'b0;
    i_code = 72'hFF_FFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    cmp("hold_valid", 64'(o_valid), 64'd0);
    cmp("hold_data", 64'(o_data), 64'(last_exp.data));
    cmp("hold_flags", 64'({o_err_corr, o_err_detec, o_err_fatal}),
        64'({last_exp.corr, last_exp.detec, last_exp.fatal}));

    for (int i = 0; i < 72; i++) begin
      cw = base_c;
      cw[i] = ~cw[i];
      send(cw, mk(base_d, 1'b1, 1'b1, 1'b0));
    end

    send(72'hb0000, mk(64'hb00, 1'b0, 1'b1, 1'b1));
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    i_code  = 72'h1000;
    @(negedge clk);
    check_zero("midreset");
    reset_n = 1'b0;
    enable  = 1'b0;

    send(72'h1000, mk(64'h0, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    cmp("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
